// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard.
// Each architectural register has a countdown of the cycles left until its
// pending result can be forwarded. An instruction stalls when it reads a
// register that is still counting (RAW). It also stalls when its own write
// would finish no later than a write already in flight (WAW). The block also
// keeps a saturating count of stall cycles.
module id_scoreboard #(
    parameter int NREG  = 32,
    parameter int IDXW  = 5,
    parameter int NSRC  = 2,
    parameter int LAT_W = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 id_valid,
    input  logic                 id_flush,
    input  logic                 ex_ready,
    input  logic [NSRC-1:0]      src_en,
    input  logic [NSRC*IDXW-1:0] src_idx,
    input  logic                 rd_en,
    input  logic [IDXW-1:0]      rd_idx,
    input  logic [LAT_W-1:0]     rd_lat,
    input  logic                 stall_cnt_clr,
    output logic                 id_ready,
    output logic                 id_fire,
    output logic                 stall,
    output logic [NSRC-1:0]      haz_src,
    output logic [NREG-1:0]      busy_vec,
    output logic [31:0]          stall_cnt
);

    typedef logic [LAT_W-1:0] cnt_t;

    cnt_t            cnt_q [NREG];
    cnt_t            cnt_d [NREG];
    logic [31:0]     stall_cnt_q;
    logic [31:0]     stall_cnt_d;
    logic [IDXW-1:0] src_k [NSRC];
    logic            rd_live;
    logic            waw;
    logic            hazard;
    cnt_t            lat_eff;

    function automatic cnt_t sat_dec(input cnt_t c);
        return (c == '0) ? '0 : c - cnt_t'(1);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] c);
        return (c == '1) ? c : c + 32'd1;
    endfunction

    // x0 and any index beyond the register file are never tracked
    function automatic logic idx_tracked(input logic [IDXW-1:0] idx);
        return (idx != '0) && (int'(idx) < NREG);
    endfunction

    // RAW check per source operand, using the state before this edge so an
    // instruction never waits on its own write
    always_comb begin
        haz_src = '0;
        for (int k = 0; k < NSRC; k++) begin
            src_k[k]   = src_idx[k*IDXW +: IDXW];
            haz_src[k] = src_en[k] && idx_tracked(src_k[k]) && (cnt_q[src_k[k]] != '0);
        end
    end

    // WAW check and issue handshake; a flush suppresses both stall and fire
    always_comb begin
        lat_eff  = (rd_lat == '0) ? cnt_t'(1) : rd_lat;
        rd_live  = rd_en && idx_tracked(rd_idx);
        waw      = rd_live && (cnt_q[rd_idx] >= lat_eff);
        hazard   = (|haz_src) || waw;
        stall    = id_valid && !id_flush && hazard;
        id_ready = ex_ready && !hazard;
        id_fire  = id_valid && !id_flush && ex_ready && !hazard;
    end

    // Countdown advances only with the pipe; a new issue overrides the decrement
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (ex_ready) begin
                cnt_d[r] = sat_dec(cnt_q[r]);
            end
        end
        if (id_fire && rd_live) begin
            cnt_d[rd_idx] = lat_eff - cnt_t'(1);
        end
        cnt_d[0] = '0;
    end

    // Busy flags mirror the nonzero countdowns
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
        busy_vec[0] = 1'b0;
    end

    // Stall-cycle counter: clear beats increment, counts even while frozen
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall) begin
            stall_cnt_d = sat_inc32(stall_cnt_q);
        end
    end

    // State registers; reset drops every pending entry at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: table of single-cycle vectors plus
// hand-written sequences for freeze, saturation, clear and reset.
module tb_id_scoreboard;

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic        id_flush;
    logic        ex_ready;
    logic [1:0]  src_en;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [9:0]  src_idx;
    logic        rd_en;
    logic [4:0]  rd_idx;
    logic [2:0]  rd_lat;
    logic        stall_cnt_clr;
    logic        id_ready;
    logic        id_fire;
    logic        stall;
    logic [1:0]  haz_src;
    logic [31:0] busy_vec;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    assign src_idx = {s1, s0};

    id_scoreboard #(.NREG(32), .IDXW(5), .NSRC(2), .LAT_W(3)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .id_valid      (id_valid),
        .id_flush      (id_flush),
        .ex_ready      (ex_ready),
        .src_en        (src_en),
        .src_idx       (src_idx),
        .rd_en         (rd_en),
        .rd_idx        (rd_idx),
        .rd_lat        (rd_lat),
        .stall_cnt_clr (stall_cnt_clr),
        .id_ready      (id_ready),
        .id_fire       (id_fire),
        .stall         (stall),
        .haz_src       (haz_src),
        .busy_vec      (busy_vec),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, fl, er;
        logic [1:0]  sen;
        logic [4:0]  a0, a1;
        logic        rde;
        logic [4:0]  rd;
        logic [2:0]  lat;
        logic        e_stall, e_fire, e_ready;
        logic [1:0]  e_haz;
        logic [31:0] e_busy;
        logic [31:0] e_scnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic fl, input logic er,
                                input logic [1:0] sen, input logic [4:0] a0,
                                input logic [4:0] a1, input logic rde,
                                input logic [4:0] rd, input logic [2:0] lat,
                                input logic e_stall, input logic e_fire,
                                input logic e_ready, input logic [1:0] e_haz,
                                input logic [31:0] e_busy, input logic [31:0] e_scnt);
        vec_t t;
        t.v = v; t.fl = fl; t.er = er; t.sen = sen; t.a0 = a0; t.a1 = a1;
        t.rde = rde; t.rd = rd; t.lat = lat;
        t.e_stall = e_stall; t.e_fire = e_fire; t.e_ready = e_ready;
        t.e_haz = e_haz; t.e_busy = e_busy; t.e_scnt = e_scnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic er,
                         input logic [1:0] sen, input logic [4:0] a0, input logic [4:0] a1,
                         input logic rde, input logic [4:0] rd, input logic [2:0] lat);
        id_valid = v; id_flush = fl; ex_ready = er; src_en = sen;
        s0 = a0; s1 = a1; rd_en = rde; rd_idx = rd; rd_lat = lat;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   adv;
        logic fired;

        rstn = 1'b0;
        stall_cnt_clr = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

        // Directed table: one vector per cycle, outputs checked before the edge
        vecs.push_back(mk(1,0,1,2'b00, 5,0,1, 5,2, 0,1,1,2'b00, 32'h0,        0)); // load x5 lat2
        vecs.push_back(mk(1,0,1,2'b01, 5,0,1, 6,1, 1,0,0,2'b01, 32'h0000_0020, 0)); // load-use bubble
        vecs.push_back(mk(1,0,1,2'b01, 5,0,1, 6,1, 0,1,1,2'b00, 32'h0,        1)); // dependent fires
        vecs.push_back(mk(1,0,1,2'b00, 0,0,1, 7,1, 0,1,1,2'b00, 32'h0,        1)); // ALU x7 lat1
        vecs.push_back(mk(1,0,1,2'b01, 7,0,1, 0,7, 0,1,1,2'b00, 32'h0,        1)); // read x7, write x0
        vecs.push_back(mk(1,0,1,2'b11, 0,7,0, 0,0, 0,1,1,2'b00, 32'h0,        1)); // x0 never busy
        vecs.push_back(mk(1,0,1,2'b00, 0,0,1, 9,4, 0,1,1,2'b00, 32'h0,        1)); // x9 lat4
        vecs.push_back(mk(1,0,1,2'b00, 0,0,1, 9,2, 1,0,0,2'b00, 32'h0000_0200, 1)); // WAW cnt3
        vecs.push_back(mk(1,0,1,2'b00, 0,0,1, 9,2, 1,0,0,2'b00, 32'h0000_0200, 2)); // WAW cnt2
        vecs.push_back(mk(1,0,1,2'b00, 0,0,1, 9,2, 0,1,1,2'b00, 32'h0000_0200, 3)); // cnt1 < 2
        vecs.push_back(mk(1,0,1,2'b00, 0,0,1, 9,6, 0,1,1,2'b00, 32'h0000_0200, 3)); // younger write
        vecs.push_back(mk(1,1,1,2'b01, 9,0,1,10,3, 0,0,0,2'b01, 32'h0000_0200, 3)); // flushed hazard
        vecs.push_back(mk(0,0,1,2'b00, 0,0,0, 0,0, 0,0,1,2'b00, 32'h0000_0200, 3)); // x10 not loaded
        vecs.push_back(mk(1,0,1,2'b00, 0,0,1,11,0, 0,1,1,2'b00, 32'h0000_0200, 3)); // lat0 on x11
        vecs.push_back(mk(1,0,1,2'b01,11,0,0, 0,0, 0,1,1,2'b00, 32'h0000_0200, 3)); // lat0 acts as 1
        vecs.push_back(mk(1,0,1,2'b01,12,0,1,12,3, 0,1,1,2'b00, 32'h0000_0200, 3)); // self-dependence
        vecs.push_back(mk(0,0,1,2'b00, 0,0,0, 0,0, 0,0,1,2'b00, 32'h0000_1000, 3)); // idle
        vecs.push_back(mk(1,0,1,2'b10,12,12,0,0,0, 1,0,0,2'b10, 32'h0000_1000, 3)); // src1 RAW only
        vecs.push_back(mk(0,0,1,2'b00, 0,0,0, 0,0, 0,0,1,2'b00, 32'h0,        4)); // drained

        // Reset state
        #12;
        check("rst_busy",  busy_vec,  32'h0);
        check("rst_scnt",  stall_cnt, 32'h0);
        check("rst_stall", {31'h0, stall},   32'h0);
        check("rst_fire",  {31'h0, id_fire}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].fl, vecs[i].er, vecs[i].sen, vecs[i].a0, vecs[i].a1,
                  vecs[i].rde, vecs[i].rd, vecs[i].lat);
            #1;
            check($sformatf("v%0d_stall", i), {31'h0, stall},    {31'h0, vecs[i].e_stall});
            check($sformatf("v%0d_fire",  i), {31'h0, id_fire},  {31'h0, vecs[i].e_fire});
            check($sformatf("v%0d_ready", i), {31'h0, id_ready}, {31'h0, vecs[i].e_ready});
            check($sformatf("v%0d_haz",   i), {30'h0, haz_src},  {30'h0, vecs[i].e_haz});
            check($sformatf("v%0d_busy",  i), busy_vec,  vecs[i].e_busy);
            check($sformatf("v%0d_scnt",  i), stall_cnt, vecs[i].e_scnt);
        end

        // Frozen pipe: x3 lat5 stays busy while ex_ready is low
        @(negedge clk);
        drive(1, 0, 1, 2'b00, 0, 0, 1, 3, 5);
        #1;
        check("t3_prod_fire", {31'h0, id_fire}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 2'b01, 3, 0, 0, 0, 0);
            #1;
            check($sformatf("t3_frz%0d_busy", i),  {31'h0, busy_vec[3]}, 32'h1);
            check($sformatf("t3_frz%0d_stall", i), {31'h0, stall},       32'h1);
            check($sformatf("t3_frz%0d_ready", i), {31'h0, id_ready},    32'h0);
        end
        adv = 0;
        fired = 1'b0;
        for (int i = 0; i < 10 && !fired; i++) begin
            @(negedge clk);
            drive(1, 0, 1, 2'b01, 3, 0, 0, 0, 0);
            #1;
            if (id_fire) fired = 1'b1;
            else adv++;
        end
        check("t3_fired",      {31'h0, fired}, 32'h1);
        check("t3_adv_stalls", adv, 32'd4);
        @(negedge clk);
        drive(0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
        #1;
        check("t3_scnt", stall_cnt, 32'd12);
        check("t3_busy", busy_vec,  32'h0);

        // Clear, then saturation near the top of the counter
        stall_cnt_clr = 1'b1;
        @(negedge clk);
        stall_cnt_clr = 1'b0;
        #1;
        check("t6_clr0", stall_cnt, 32'h0);
        drive(1, 0, 1, 2'b00, 0, 0, 1, 4, 7);
        #1;
        check("t6_x4_fire", {31'h0, id_fire}, 32'h1);
        @(negedge clk);
        drive(1, 0, 1, 2'b01, 4, 0, 0, 0, 0);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        check("t6_stall", {31'h0, stall}, 32'h1);
        @(negedge clk);
        #1;
        check("t6_sat1", stall_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t6_sat3", stall_cnt, 32'hFFFF_FFFF);
        stall_cnt_clr = 1'b1;
        @(negedge clk);
        stall_cnt_clr = 1'b0;
        drive(0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
        #1;
        check("t6_clr_prio", stall_cnt, 32'h0);
        check("t6_x4_busy",  busy_vec,  32'h0000_0010);

        // Asynchronous reset drops pending entries immediately
        rstn = 1'b0;
        #1;
        check("t6_rst_busy", busy_vec,  32'h0);
        check("t6_rst_scnt", stall_cnt, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1, 0, 1, 2'b01, 4, 0, 0, 0, 0);
        #1;
        check("t6_post_stall", {31'h0, stall},   32'h0);
        check("t6_post_fire",  {31'h0, id_fire}, 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
